// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared command codes, command width and sequencer state type
package lcd_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_WRITE = 3'd0;
  localparam logic [CMD_W-1:0] CMD_UP    = 3'd1;
  localparam logic [CMD_W-1:0] CMD_DOWN  = 3'd2;
  localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd3;
  localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd4;
  localparam logic [CMD_W-1:0] CMD_AVG   = 3'd5;
  localparam logic [CMD_W-1:0] CMD_MIRX  = 3'd6;
  localparam logic [CMD_W-1:0] CMD_MIRY  = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    HOLD,
    WAIT_BUSY,
    WAIT_DONE
  } seq_state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - circular command FIFO with occupancy count
// Ports: clk, reset (async, active-low); push/push_data write side;
//        pop/pop_data read side (pop_data always shows the head entry);
//        count = entries queued; ready = not full, decoded from the count register.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign ready    = (count != FULL);
  assign do_push  = push && ready;
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// rtl/lcd_cmd_seq.sv - queues host commands and issues them one at a time to LCD_CTRL
// Ports: clk, reset (async, active-low);
//        in_cmd/in_valid/in_ready host command handshake;
//        busy/done status from LCD_CTRL; cmd/cmd_valid issue to LCD_CTRL;
//        fifo_count queued commands; frame_cnt completed Write frames (8-bit wrap).
module lcd_cmd_seq #(
  parameter int DEPTH = 8,
  parameter int CMD_W = lcd_pkg::CMD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CMD_W-1:0]       in_cmd,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   busy,
  input  logic                   done,
  output logic [CMD_W-1:0]       cmd,
  output logic                   cmd_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             frame_cnt
);

  import lcd_pkg::*;

  seq_state_t       state;
  seq_state_t       state_nx;
  logic             pop;
  logic             frame_end;
  logic [CMD_W-1:0] head;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_cmd),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .ready     (in_ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd       <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        cmd <= head;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // fifo_count is registered, so an entry pushed on this edge is not yet
  // visible here and cannot be issued until the following edge.
  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    cmd_valid = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if ((fifo_count != '0) && !busy) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        state_nx  = HOLD;
      end
      // Gives LCD_CTRL a cycle to raise busy before it is sampled.
      HOLD: begin
        state_nx = (cmd == CMD_W'(CMD_WRITE)) ? WAIT_DONE : WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!busy) begin
          state_nx = IDLE;
        end
      end
      // A Write completes only on done; busy is deliberately not looked at.
      WAIT_DONE: begin
        if (done) begin
          frame_end = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
